// File: rtl/axis_fifo_egress.sv
// axis_fifo_egress: reader side of axis_fifo. Pops FIFO words and drives an AXI4-Stream
// master. A 2-entry output buffer hides the FIFO's 1-cycle read latency so the stream
// can run at one beat per cycle. The en input stops reading only at a packet boundary.
// pkt_count counts packets handed downstream.
module axis_fifo_egress #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  en,
  // FIFO read port; data returns the cycle after fifo_rd_en
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_tdata,
  input  logic [KEEP_WIDTH-1:0] fifo_tkeep,
  input  logic                  fifo_tlast,
  input  logic [USER_WIDTH-1:0] fifo_tuser,
  // AXI4-Stream master
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  // status
  output logic                  in_pkt,
  output logic [31:0]           pkt_count
);

  localparam int unsigned BeatWidth = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  typedef logic [BeatWidth-1:0] beat_t;

  // Two-entry buffer: head_q is what m_axis presents, tail_q is only meaningful when occ_q == 2.
  beat_t       head_q, head_d;
  beat_t       tail_q, tail_d;
  logic [1:0]  occ_q, occ_d;
  logic        inflight_q;
  logic        in_pkt_q, in_pkt_d;
  logic [31:0] pkt_count_q, pkt_count_d;

  beat_t       fifo_beat;
  logic        pop;
  logic        capture;
  logic        gate;
  logic [2:0]  credit;

  assign fifo_beat = {fifo_tdata, fifo_tkeep, fifo_tlast, fifo_tuser};

  assign m_axis_tvalid = (occ_q != 2'd0);
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = head_q;

  assign pop     = m_axis_tvalid & m_axis_tready;
  // The word requested last cycle lands in the buffer at this edge.
  assign capture = inflight_q;

  // Entries committed after this edge; a new read is allowed only while that stays below two,
  // which is what keeps the buffer from ever overflowing.
  assign credit = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};

  // With en low, keep reading only inside an open packet, one word at a time, so the tlast
  // of each returned word is known before another read is issued.
  assign gate = en | (in_pkt_q & ~inflight_q);

  assign fifo_rd_en = ~fifo_empty & (credit < 3'd2) & gate;

  assign in_pkt    = in_pkt_q;
  assign pkt_count = pkt_count_q;

  // Buffer next state: write captured word to the tail position, advance head on pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case ({capture, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = fifo_beat;
        end else begin
          tail_d = fifo_beat;
        end
      end
      2'b01: begin
        // Head only changes when there is a second entry to advance to.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
        end
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = fifo_beat;
        end else begin
          head_d = fifo_beat;
        end
      end
      default: begin
      end
    endcase
  end

  // Occupancy, packet-open flag and delivered-packet counter next state.
  always_comb begin
    occ_d       = occ_q + {1'b0, capture} - {1'b0, pop};
    in_pkt_d    = in_pkt_q;
    pkt_count_d = pkt_count_q;
    if (capture) begin
      in_pkt_d = ~fifo_tlast;
    end
    if (pop && m_axis_tlast) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  // State registers; synchronous reset drops any word still returning from the FIFO.
  always_ff @(posedge aclk) begin
    if (areset) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      in_pkt_q    <= 1'b0;
      pkt_count_q <= 32'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      inflight_q  <= fifo_rd_en;
      in_pkt_q    <= in_pkt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

`ifndef SYNTHESIS
  // Buffered plus in-flight words never exceed the two buffer entries.
  a_credit: assert property (@(posedge aclk) disable iff (areset)
    (({1'b0, occ_q} + {2'b0, inflight_q}) <= 3'd2));

  // A stalled beat stays valid and unchanged until it is accepted.
  a_hold: assert property (@(posedge aclk) disable iff (areset)
    (m_axis_tvalid && !m_axis_tready) |=> (m_axis_tvalid && $stable(head_q)));
`endif

endmodule

// File: tb/tb_axis_fifo_egress.sv
// tb_axis_fifo_egress: behavioural FIFO model feeding axis_fifo_egress, with an expected-beat
// queue filled as words are written and drained as beats are accepted downstream.
module tb_axis_fifo_egress;

  localparam int unsigned DW = 64;
  localparam int unsigned UW = 128;
  localparam int unsigned KW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          en = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_tdata;
  logic [KW-1:0] fifo_tkeep;
  logic          fifo_tlast;
  logic [UW-1:0] fifo_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          in_pkt;
  logic [31:0]   pkt_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // FIFO model: 1-cycle read latency, cleared by areset.
  beat_t       mem [256];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  beat_t       fifo_out = '0;
  beat_t       exp_q[$];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_tdata = fifo_out.d;
  assign fifo_tkeep = fifo_out.k;
  assign fifo_tlast = fifo_out.l;
  assign fifo_tuser = fifo_out.u;

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && !fifo_empty) fifo_out <= mem[rd_ptr[7:0]];
    if (areset) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  axis_fifo_egress #(
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW),
    .KEEP_WIDTH(KW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_tdata   (fifo_tdata),
    .fifo_tkeep   (fifo_tkeep),
    .fifo_tlast   (fifo_tlast),
    .fifo_tuser   (fifo_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .in_pkt       (in_pkt),
    .pkt_count    (pkt_count)
  );

  // Write one word into the FIFO model and record it as an expected output beat.
  task automatic push(input logic [DW-1:0] d, input logic l, input logic [UW-1:0] u);
    beat_t b;
    b.d = d;
    b.k = 8'hFF;
    b.l = l;
    b.u = u;
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid);
    end
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en);
    end
    checks++;
    if (in_pkt !== 1'b0 || pkt_count !== 32'd0) begin
      errors++; $display("FAIL reset_status in_pkt=%b pkt_count=%0d want 0/0", in_pkt, pkt_count);
    end
    checks++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%b/%h want all zero",
                         m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  // Full-rate stream: 10 beats back to back, 2-cycle read-to-valid latency.
  task automatic test_stream();
    beat_t got, exp;
    int first_rd = -1;
    int first_v = -1;
    int last_v = -1;
    en = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) push(DW'(i), (i == 9), UW'(i));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(negedge aclk);
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (m_axis_tvalid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL stream_beat got=%h want=%h", got, exp);
        end
      end
      @(posedge aclk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stream_timeout remaining=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (first_v - first_rd != 2) begin
      errors++; $display("FAIL stream_latency got=%0d want=2", first_v - first_rd);
    end
    checks++;
    if (last_v - first_v != 9) begin
      errors++; $display("FAIL stream_bubbles span=%0d want=9", last_v - first_v);
    end
    repeat (2) @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || pkt_count !== 32'd1) begin
      errors++; $display("FAIL stream_end tvalid=%b pkt_count=%0d want 0/1", m_axis_tvalid, pkt_count);
    end
    @(posedge aclk); #1;
  endtask

  // Backpressure with tready 1,0,0,1: order, stall stability and read credit.
  task automatic test_backpressure();
    beat_t got, exp, held;
    logic stalled = 1'b0;
    int rd_cnt = 0;
    int pop_cnt = 0;
    int pop_now;
    held = '0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) push(DW'(i), (i == 9), UW'(i));
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge aclk);
      got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      pop_now = (m_axis_tvalid && m_axis_tready) ? 1 : 0;
      if (stalled) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || got !== held) begin
          errors++; $display("FAIL bp_stable tvalid=%b got=%h want=%h", m_axis_tvalid, got, held);
        end
      end
      if (fifo_rd_en) begin
        checks++;
        if (rd_cnt - pop_cnt - pop_now >= 2) begin
          errors++; $display("FAIL bp_credit outstanding=%0d want <2", rd_cnt - pop_cnt - pop_now);
        end
      end
      if (pop_now == 1) begin
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL bp_beat got=%h want=%h", got, exp);
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held = got;
      rd_cnt += fifo_rd_en ? 1 : 0;
      pop_cnt += pop_now;
      @(posedge aclk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL bp_timeout remaining=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++;
    if (pkt_count !== 32'd2) begin
      errors++; $display("FAIL bp_pkt_count got=%0d want=2", pkt_count);
    end
    @(posedge aclk); #1;
  endtask

  // en dropped while the first word of packet 1 is in flight: packet 1 completes, packet 2 waits.
  task automatic test_boundary_stop();
    beat_t got, exp;
    int reads = 0;
    int beats = 0;
    en = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(32'h100 + i), (i == 3), UW'(i));
    for (int i = 0; i < 4; i++) push(DW'(32'h200 + i), (i == 3), UW'(i));
    @(negedge aclk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++; $display("FAIL stop_first_read got=%b want=1", fifo_rd_en);
    end
    @(posedge aclk); #1;
    en = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge aclk);
      if (fifo_rd_en) reads++;
      if (m_axis_tvalid) begin
        beats++;
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL stop_beat got=%h want=%h", got, exp);
        end
      end
      @(posedge aclk); #1;
    end
    checks++;
    if (reads != 3 || beats != 4) begin
      errors++; $display("FAIL stop_counts reads=%0d beats=%0d want 3/4", reads, beats);
    end
    @(negedge aclk);
    checks++;
    if (in_pkt !== 1'b0 || pkt_count !== 32'd3 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL stop_state in_pkt=%b pkt_count=%0d tvalid=%b want 0/3/0",
                         in_pkt, pkt_count, m_axis_tvalid);
    end
    @(posedge aclk); #1;
    en = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) begin
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL resume_beat got=%h want=%h", got, exp);
        end
      end
      @(posedge aclk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL resume_timeout remaining=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++;
    if (pkt_count !== 32'd4) begin
      errors++; $display("FAIL resume_pkt_count got=%0d want=4", pkt_count);
    end
    @(posedge aclk); #1;
  endtask

  // Buffer full with FIFO empty, then drain.
  task automatic test_drain_empty();
    beat_t got, exp;
    int beats = 0;
    int stray_rd = 0;
    en = 1'b1;
    m_axis_tready = 1'b0;
    push(DW'(32'h300), 1'b0, UW'(7));
    push(DW'(32'h301), 1'b1, UW'(8));
    repeat (6) @(posedge aclk);
    #1;
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL drain_full tvalid=%b rd_en=%b want 1/0", m_axis_tvalid, fifo_rd_en);
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (fifo_rd_en) stray_rd++;
      if (m_axis_tvalid) begin
        beats++;
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL drain_beat got=%h want=%h", got, exp);
        end
      end
      @(posedge aclk); #1;
    end
    checks++;
    if (beats != 2 || stray_rd != 0 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL drain_end beats=%0d reads=%0d tvalid=%b want 2/0/0",
                         beats, stray_rd, m_axis_tvalid);
    end
    checks++;
    if (pkt_count !== 32'd5) begin
      errors++; $display("FAIL drain_pkt_count got=%0d want=5", pkt_count);
    end
  endtask

  // Synchronous reset while a word is in flight and one is buffered.
  task automatic test_reset_midstream();
    int stray = 0;
    en = 1'b1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'h400 + i), (i == 3), UW'(i));
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || in_pkt !== 1'b1) begin
      errors++; $display("FAIL rst_pre tvalid=%b in_pkt=%b want 1/1", m_axis_tvalid, in_pkt);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || pkt_count !== 32'd0 || in_pkt !== 1'b0) begin
      errors++; $display("FAIL rst_post tvalid=%b pkt_count=%0d in_pkt=%b want 0/0/0",
                         m_axis_tvalid, pkt_count, in_pkt);
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) stray++;
      @(posedge aclk); #1;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rst_stray_beats got=%0d want=0", stray);
    end
  endtask

  // Counter wrap from 0xFFFF_FFFF on a single-beat packet.
  task automatic test_count_wrap();
    beat_t got, exp;
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    @(posedge aclk); #1;
    release dut.pkt_count_q;
    @(negedge aclk);
    checks++;
    if (pkt_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preload got=%h want=ffffffff", pkt_count);
    end
    @(posedge aclk); #1;
    en = 1'b1;
    m_axis_tready = 1'b1;
    push(DW'(64'hDEAD_BEEF_0000_0001), 1'b1, UW'(5));
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) begin
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL wrap_beat got=%h want=%h", got, exp);
        end
      end
      @(posedge aclk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_timeout remaining=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (pkt_count !== 32'd0) begin
      errors++; $display("FAIL wrap_count got=%h want=0", pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_boundary_stop();
    test_drain_empty();
    test_reset_midstream();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
